piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per enabled clock, with first-bit and last-bit framing strobes. A one-word holding register lets consecutive words stream out with no idle bit between them. It drives serial links from the parallel register stage that feeds it.

Parameters:
WIDTH, 4, word width in bits; must be 2 or more.
MSB_FIRST, 1, 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
clk  input  1  clock; rising edge.
rstn  input  1  asynchronous active-low reset.
in_data  input  WIDTH  parallel word; sampled only on accept.
in_valid  input  1  upstream has a word.
in_ready  output  1  holding register can take a word.
ser_en  input  1  bit-rate enable; tie high for one bit per clock.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out carries a data bit.
ser_first  output  1  ser_out is bit 0 of the frame.
ser_last  output  1  ser_out is the final bit of the frame.
busy  output  1  a word is shifting or pending.

Behaviour:
- Reset: clk single clock; rstn asynchronous active-low.
  - While rstn=0, all registers clear immediately: state=IDLE, sr=0, cnt=0, hold_full=0.
  - While rstn=0, ser_out/ser_valid/ser_first/ser_last/busy=0 and in_ready=0.
  - in_ready is gated low by rstn.
- Internal state: shift register sr[WIDTH], bit counter cnt (clog2(WIDTH) bits), hold_data[WIDTH], hold_full, and FSM state IDLE/SHIFT.
- Accept:
  - A word is accepted at a rising edge when in_valid && in_ready.
  - in_ready = rstn && !hold_full.
  - On accept, hold_data <= in_data and hold_full <= 1.
- IDLE:
  - If hold_full: sr <= hold_data, cnt <= 0, hold_full <= 0, state <= SHIFT.
  - A word accepted at edge E0 therefore loads at E1. The first bit is visible right after E1, so latency is 1 clock from accept.
- SHIFT:
  - ser_valid=1.
  - ser_out = MSB_FIRST ? sr[WIDTH-1] : sr[0].
  - A bit is consumed at each edge with ser_en=1. sr shifts toward the output end with 0 fill, and cnt increments.
  - With ser_en=0, sr and cnt hold and all outputs are stable.
- Last bit (cnt==WIDTH-1 && ser_en):
  - If hold_full, load hold_data into sr, set cnt=0, clear hold_full, and stay in SHIFT. This is gapless.
  - Otherwise go to IDLE.
- Simultaneous events: in_ready is registered-low while hold_full=1, so an accept cannot coincide with a hold-to-sr transfer. in_ready rises the cycle after the transfer.
- Strobes: ser_first = SHIFT && cnt==0; ser_last = SHIFT && cnt==WIDTH-1.
- IDLE outputs: ser_out=0, ser_valid=0, ser_first=0, ser_last=0.
- busy = (state==SHIFT) || hold_full.
- Reset mid-word: the in-flight word and the pending word are discarded. There is no partial output after rstn releases.
- in_data changes outside an accept are ignored. in_valid may drop without being accepted.

Decomposition:
- No shared package. The state encoding (IDLE=1'b0, SHIFT=1'b1) is local.
- Natural sub-module: hold_reg, a WIDTH-bit enabled register with async active-low clear and a full flag.
- The top level contains the FSM, shifter and counter.

Test Plan:
1. rstn=0 for 3 clocks, then release, no in_valid -> all outputs 0 during reset; after release in_ready=1, ser_valid=0, busy=0.
2. WIDTH=4, MSB_FIRST=1, ser_en=1, one word 4'b1011 accepted at E0 -> from E1, ser_out=1,0,1,1 on 4 consecutive cycles. ser_first is high on the 1st bit and ser_last on the 4th. Then ser_valid=0 and busy=0.
3. Back-to-back words 4'b1011 then 4'b0110, in_valid held high -> 8 contiguous bits 1,0,1,1,0,1,1,0 with ser_valid never dropping. in_ready is low while the second word waits in hold.
4. Word 4'b1001 with ser_en pattern 1,0,0,1,1,0,1 -> each bit is held across ser_en=0 cycles. The bits emitted are 1,0,0,1. ser_last clears at the 4th enabled edge.
5. MSB_FIRST=0, word 4'b1011 -> ser_out=1,1,0,1.
6. rstn pulsed low asynchronously (between edges) after 2 bits of 4'b1011 while 4'b1111 is pending -> outputs drop to 0 immediately. After release: idle, hold empty. Then 4'b0101 serializes as 0,1,0,1.

Source files
------------

// File: rtl/piso_serializer_hold_reg.sv
// One-word holding register in front of the shifter: captures an accepted word
// and flags it as pending until the shifter takes it.
module piso_serializer_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // A load only happens while empty and a take only while full, so the two never collide.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = d;
      full_d = 1'b1;
    end else if (take) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= {WIDTH{1'b0}};
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign q    = data_q;
  assign full = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one holding slot,
// and a shifter that emits one bit per enabled clock with first/last strobes.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_q, ser_valid_q, ser_first_q, ser_last_q;
  logic             ser_out_d, ser_valid_d, ser_first_d, ser_last_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;
  logic             take;

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign in_ready = rstn & ~hold_full;
  assign accept   = in_valid & in_ready;

  piso_serializer_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk  (clk),
    .rstn (rstn),
    .load (accept),
    .take (take),
    .d    (in_data),
    .q    (hold_data),
    .full (hold_full)
  );

  // Next-state for FSM, shifter and counter; output strobes are decoded from the next state.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full) begin
          take    = 1'b1;
          sr_d    = hold_data;
          cnt_d   = {CNT_W{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (cnt_q == CNT_LAST) begin
            if (hold_full) begin
              take  = 1'b1;
              sr_d  = hold_data;
              cnt_d = {CNT_W{1'b0}};
            end else begin
              sr_d    = shift_once(sr_q);
              cnt_d   = {CNT_W{1'b0}};
              state_d = IDLE;
            end
          end else begin
            sr_d  = shift_once(sr_q);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    ser_valid_d = (state_d == SHIFT);
    ser_out_d   = ser_valid_d ? out_bit(sr_d) : 1'b0;
    ser_first_d = ser_valid_d && (cnt_d == {CNT_W{1'b0}});
    ser_last_d  = ser_valid_d && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sr_q        <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q == SHIFT) | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one stimulus
// and are checked against hand vectors and a word/bit-position reference model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         ser_en;
  logic         rdy_m, out_m, val_m, fst_m, lst_m, busy_m;
  logic         rdy_l, out_l, val_l, fst_l, lst_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .ser_en(ser_en), .ser_out(out_m), .ser_valid(val_m), .ser_first(fst_m),
    .ser_last(lst_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .ser_en(ser_en), .ser_out(out_l), .ser_valid(val_l), .ser_first(fst_l),
    .ser_last(lst_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame in flight (word + bit position) and at most one pending word.
  logic         m_active, m_pend;
  int           m_idx;
  logic [W-1:0] m_cur, m_pw;

  always @(posedge clk or negedge rstn) begin
    logic acc;
    if (!rstn) begin
      m_active = 1'b0; m_pend = 1'b0; m_idx = 0; m_cur = '0; m_pw = '0;
    end else begin
      acc = in_valid && !m_pend;
      if (!m_active) begin
        if (m_pend) begin m_cur = m_pw; m_idx = 0; m_pend = 1'b0; m_active = 1'b1; end
      end else if (ser_en) begin
        if (m_idx == W - 1) begin
          if (m_pend) begin m_cur = m_pw; m_idx = 0; m_pend = 1'b0; end
          else m_active = 1'b0;
        end else begin
          m_idx++;
        end
      end
      if (acc) begin m_pend = 1'b1; m_pw = in_data; end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    logic [4:0] ef;
    logic       eo_m, eo_l;
    ef   = {rstn && !m_pend, m_active || m_pend, m_active,
            m_active && (m_idx == 0), m_active && (m_idx == W - 1)};
    eo_m = m_active ? m_cur[W-1-m_idx] : 1'b0;
    eo_l = m_active ? m_cur[m_idx] : 1'b0;
    chk("model_m", {26'd0, rdy_m, busy_m, val_m, fst_m, lst_m, out_m}, {26'd0, ef, eo_m});
    chk("model_l", {26'd0, rdy_l, busy_l, val_l, fst_l, lst_l, out_l}, {26'd0, ef, eo_l});
  end

  // flags = {in_ready, busy, ser_valid, ser_first, ser_last}
  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    logic         en;
    logic [4:0]   flags;
    logic         om;
    logic         ol;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [W-1:0] d, input logic e,
                     input logic [4:0] f, input logic om, input logic ol);
    vec_t r;
    r.vld = v; r.data = d; r.en = e; r.flags = f; r.om = om; r.ol = ol;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] w;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; ser_en = 1'b1;

    // Reset held for 3 clocks
    repeat (3) begin
      @(negedge clk);
      chk("rst_m", {26'd0, rdy_m, busy_m, val_m, fst_m, lst_m, out_m}, 32'd0);
      chk("rst_l", {26'd0, rdy_l, busy_l, val_l, fst_l, lst_l, out_l}, 32'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst", {29'd0, rdy_m, busy_m, val_m}, {29'd0, 1'b1, 1'b0, 1'b0});
    step();

    // Single word 1011
    add(1, 4'b1011, 1, 5'b10000, 0, 0);
    add(0, 4'b0000, 1, 5'b01000, 0, 0);
    add(0, 4'b0000, 1, 5'b11110, 1, 1);
    add(0, 4'b0000, 1, 5'b11100, 0, 1);
    add(0, 4'b0000, 1, 5'b11100, 1, 0);
    add(0, 4'b0000, 1, 5'b11101, 1, 1);
    add(0, 4'b0000, 1, 5'b10000, 0, 0);
    // Back-to-back 1011, 0110 with in_valid held
    add(1, 4'b1011, 1, 5'b10000, 0, 0);
    add(1, 4'b0110, 1, 5'b01000, 0, 0);
    add(1, 4'b0110, 1, 5'b11110, 1, 1);
    add(0, 4'b0000, 1, 5'b01100, 0, 1);
    add(0, 4'b0000, 1, 5'b01100, 1, 0);
    add(0, 4'b0000, 1, 5'b01101, 1, 1);
    add(0, 4'b0000, 1, 5'b11110, 0, 0);
    add(0, 4'b0000, 1, 5'b11100, 1, 1);
    add(0, 4'b0000, 1, 5'b11100, 1, 1);
    add(0, 4'b0000, 1, 5'b11101, 0, 0);
    add(0, 4'b0000, 1, 5'b10000, 0, 0);
    // 1001 with ser_en pattern 1,0,0,1,1,0,1
    add(1, 4'b1001, 1, 5'b10000, 0, 0);
    add(0, 4'b0000, 1, 5'b01000, 0, 0);
    add(0, 4'b0000, 1, 5'b11110, 1, 1);
    add(0, 4'b0000, 0, 5'b11100, 0, 0);
    add(0, 4'b0000, 0, 5'b11100, 0, 0);
    add(0, 4'b0000, 1, 5'b11100, 0, 0);
    add(0, 4'b0000, 1, 5'b11100, 0, 0);
    add(0, 4'b0000, 0, 5'b11101, 1, 1);
    add(0, 4'b0000, 1, 5'b11101, 1, 1);
    add(0, 4'b0000, 1, 5'b10000, 0, 0);

    foreach (tbl[i]) begin
      in_valid = tbl[i].vld; in_data = tbl[i].data; ser_en = tbl[i].en;
      @(negedge clk);
      chk($sformatf("tbl%0d_fm", i), {27'd0, rdy_m, busy_m, val_m, fst_m, lst_m}, {27'd0, tbl[i].flags});
      chk($sformatf("tbl%0d_fl", i), {27'd0, rdy_l, busy_l, val_l, fst_l, lst_l}, {27'd0, tbl[i].flags});
      chk($sformatf("tbl%0d_om", i), {31'd0, out_m}, {31'd0, tbl[i].om});
      chk($sformatf("tbl%0d_ol", i), {31'd0, out_l}, {31'd0, tbl[i].ol});
      step();
    end
    in_valid = 1'b0; ser_en = 1'b1;
    step();

    // Async reset after 2 bits of 1011 while 1111 is pending
    in_valid = 1'b1; in_data = 4'b1011; step();
    in_data = 4'b1111; step();
    step();
    in_valid = 1'b0; step();
    chk("pre_rst_pend", {30'd0, busy_m, rdy_m}, {30'd0, 1'b1, 1'b0});
    #2 rstn = 1'b0;
    #1;
    chk("async_m", {26'd0, rdy_m, busy_m, val_m, fst_m, lst_m, out_m}, 32'd0);
    chk("async_l", {26'd0, rdy_l, busy_l, val_l, fst_l, lst_l, out_l}, 32'd0);
    @(negedge clk); #2 rstn = 1'b1;
    step();
    @(negedge clk);
    chk("after_rst", {29'd0, rdy_m, busy_m, val_m}, {29'd0, 1'b1, 1'b0, 1'b0});
    step();
    w = 4'b0101;
    in_valid = 1'b1; in_data = w; step();
    in_valid = 1'b0; step();
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk($sformatf("post_m_b%0d", k), {30'd0, val_m, out_m}, {30'd0, 1'b1, w[W-1-k]});
      chk($sformatf("post_l_b%0d", k), {30'd0, val_l, out_l}, {30'd0, 1'b1, w[k]});
      step();
    end
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      ser_en   = ($urandom_range(0, 4) != 0);
      step();
    end
    in_valid = 1'b0; ser_en = 1'b1;
    repeat (12) step();
    chk("drain_idle", {30'd0, busy_m, busy_l}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
